// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU types and constants for the carry-lookahead
//                adder family (4-bit leaf cells and wider CLA trees).
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Width of one carry-lookahead leaf cell.
    localparam int CLA_W = 4;

    // One operand nibble of a leaf cell.
    typedef logic [CLA_W-1:0] nibble_t;

    // Group propagate/generate pair handed up to the next lookahead level.
    typedef struct {
        logic p;
        logic g;
    } pg_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/cla4_lookahead_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cla4_lookahead_unit
//  Description : Two-level carry-lookahead network for a 4-bit group.
//                Every carry is a flat sum of products of the bit
//                propagate/generate terms and the carry in; no carry
//                ever feeds another carry.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla4_lookahead_unit
    import alu_pkg::*;
(
    input  nibble_t    p,
    input  nibble_t    g,
    input  logic       cin,
    output logic [4:1] c,
    output logic       pg,
    output logic       gg
);

    // Flat lookahead carries, group propagate and group generate.
    always_comb begin
        c[1] = g[0]
             | (p[0] & cin);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & cin);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        pg   = p[3] & p[2] & p[1] & p[0];
        gg   = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule : cla4_lookahead_unit
`default_nettype wire

// File: rtl/cla4_adder.sv
`default_nettype none
// ============================================================================
//  Module      : cla4_adder
//  Description : 4-bit carry-lookahead adder. Zero-latency sum/carry-out,
//                group propagate/generate for cascading into wider trees,
//                and a one-cycle registered copy of the result with an
//                asynchronous active-high clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla4_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             pg,
    output logic             gg,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q
);

    // The lookahead equations only exist for a 4-bit group.
    if (WIDTH != CLA_W) begin : g_width_check
        $error("cla4_adder: WIDTH must be 4");
    end

    nibble_t    w_p;
    nibble_t    w_g;
    nibble_t    w_c;
    logic [4:1] w_carry;
    pg_t        w_grp;

    // Bit-level propagate and generate terms.
    always_comb begin
        w_p = a ^ b;
        w_g = a & b;
    end

    cla4_lookahead_unit u_lookahead (
        .p   (w_p),
        .g   (w_g),
        .cin (cin),
        .c   (w_carry),
        .pg  (w_grp.p),
        .gg  (w_grp.g)
    );

    // Carry into each bit position, then the sum bits and group outputs.
    always_comb begin
        w_c  = {w_carry[3:1], cin};
        sum  = w_p ^ w_c;
        cout = w_carry[4];
        pg   = w_grp.p;
        gg   = w_grp.g;
    end

    // Pipeline copy of the result; rst clears it immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum;
            cout_q <= cout;
        end
    end

endmodule : cla4_adder
`default_nettype wire

// File: tb/tb_cla4_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla4_adder
//  Description : Scoreboard bench for cla4_adder. The driver pushes the
//                arithmetic expectation for each applied vector; two
//                monitors pop and compare the combinational and the
//                registered outputs independently.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cla4_adder;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [4:0] res;
        logic       pg;
        logic       gg;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       pg;
    logic       gg;
    logic [3:0] sum_q;
    logic       cout_q;

    exp_t       r_comb_q[$];
    logic [4:0] r_reg_q[$];

    int checks = 0;
    int errors = 0;

    cla4_adder #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sum    (sum),
        .cout   (cout),
        .pg     (pg),
        .gg     (gg),
        .sum_q  (sum_q),
        .cout_q (cout_q)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [3:0] ma, input logic [3:0] mb, input logic mc);
        exp_t e;
        int   s;
        s     = int'(ma) + int'(mb) + int'(mc);
        e.a   = ma;
        e.b   = mb;
        e.cin = mc;
        e.res = s[4:0];
        e.pg  = ((int'(ma) + int'(mb)) == 15);
        e.gg  = ((int'(ma) + int'(mb)) > 15);
        return e;
    endfunction

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    // Apply one vector and post both expectations to the scoreboard.
    task automatic drive(input logic [3:0] da, input logic [3:0] db, input logic dc);
        exp_t e;
        a   = da;
        b   = db;
        cin = dc;
        e   = model(da, db, dc);
        r_comb_q.push_back(e);
        r_reg_q.push_back(e.res);
    endtask

    // Combinational monitor: 1 ns after each vector is applied.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (r_comb_q.size() != 0) begin
                e = r_comb_q.pop_front();
                check($sformatf("sum a=%0d b=%0d cin=%0d", e.a, e.b, e.cin), {cout, sum}, e.res);
                check($sformatf("pg a=%0d b=%0d", e.a, e.b), {4'd0, pg}, {4'd0, e.pg});
                check($sformatf("gg a=%0d b=%0d", e.a, e.b), {4'd0, gg}, {4'd0, e.gg});
            end
        end
    end

    // Registered monitor: just after the capturing edge.
    initial begin
        logic [4:0] r;
        forever begin
            @(posedge clk);
            #1;
            if (r_reg_q.size() != 0) begin
                r = r_reg_q.pop_front();
                check("registered", {cout_q, sum_q}, r);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("reset state", {cout_q, sum_q}, 5'd0);
        rst = 1'b0;

        // Boundaries and full propagate chain.
        @(negedge clk); drive(4'd15, 4'd15, 1'b1);
        @(negedge clk); drive(4'd0,  4'd0,  1'b0);
        @(negedge clk); drive(4'b1010, 4'b0101, 1'b1);
        @(negedge clk); drive(4'b1010, 4'b0101, 1'b0);

        // Exhaustive sweep.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = i[8:0];
            @(negedge clk);
            drive(v[3:0], v[7:4], v[8]);
        end

        // Random vectors.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            drive(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
        end

        // Registered path: capture 9+8, then change inputs mid-cycle.
        @(negedge clk); drive(4'd9, 4'd8, 1'b0);
        @(posedge clk);
        #3;
        a = 4'd3; b = 4'd2; cin = 1'b1;
        #1;
        check("hold mid-cycle", {cout_q, sum_q}, 5'd17);
        @(posedge clk);
        #1;
        check("capture changed", {cout_q, sum_q}, 5'd6);

        // Async reset between edges.
        #2;
        rst = 1'b1;
        #1;
        check("async clear", {cout_q, sum_q}, 5'd0);
        check("comb during reset", {cout, sum}, 5'd6);
        @(posedge clk);
        #1;
        check("held in reset", {cout_q, sum_q}, 5'd0);

        // Release; first capture on the next rising edge.
        @(negedge clk);
        rst = 1'b0;
        drive(4'd15, 4'd15, 1'b1);
        @(negedge clk); drive(4'd7, 4'd1, 1'b0);

        // Drain and confirm every expectation was consumed.
        @(negedge clk);
        @(negedge clk);
        #2;
        checks++;
        if (r_comb_q.size() != 0 || r_reg_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d/%0d required=0/0", r_comb_q.size(), r_reg_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cla4_adder
`default_nettype wire
